// File: rtl/adi_spi_7_8bit_driver.sv
// -----------------------------------------------------------------------------
// adi_spi_7_8bit_driver
//
// 3-wire (shared SDIO) SPI master for ADI-style register ports that use a
// 7-bit address and 8-bit data. Each user request becomes one 16-bit frame,
// sent MSB first as {r/w, addr[6:0], data[7:0]}, with r/w = 1 for a read.
// The block also drives the device hard-reset pin and the direction control
// of the external SDIO level translator.
//
// Parameters
//   CLK_FRE   system clock frequency in Hz
//   SCLK_FRE  SPI clock frequency in Hz. DIV = CLK_FRE/SCLK_FRE clocks per
//             bit, which must be even and >= 4.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   user_wr_en/addr/data     one-cycle write request
//   user_rd_en/addr          one-cycle read request
//   user_rd_data             last read result, held until the next read ends
//   user_op_busy             high during device reset and during any frame
//   user_wr_vild             one-cycle pulse when a write frame completes
//   user_rd_vild             one-cycle pulse when a read completes; valid
//                            together with user_rd_data
//   rst_spi_pin              device reset, active low
//   scb, sclk, sdio          chip select (low active), SPI clock (idle low),
//                            bidirectional data
//   dir                      1 = FPGA drives sdio, 0 = device drives sdio
// -----------------------------------------------------------------------------
module adi_spi_7_8bit_driver #(
  parameter int CLK_FRE  = 100_000_000,
  parameter int SCLK_FRE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       user_wr_en,
  input  logic [6:0] user_wr_addr,
  input  logic [7:0] user_wr_data,
  input  logic       user_rd_en,
  input  logic [6:0] user_rd_addr,
  output logic [7:0] user_rd_data,
  output logic       user_op_busy,
  output logic       user_wr_vild,
  output logic       user_rd_vild,
  output logic       rst_spi_pin,
  output logic       scb,
  output logic       sclk,
  inout  wire        sdio,
  output logic       dir
);

  localparam int DIV      = CLK_FRE / SCLK_FRE;
  localparam int HALF     = DIV / 2;
  localparam int INIT_CYC = CLK_FRE / 1000;   // 1 ms device reset
  localparam int CNT_MAX  = (INIT_CYC > DIV) ? INIT_CYC : DIV;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;        // shared: reset timer, half-period and bit-period timer
  logic [3:0]       bit_idx;    // index into frame of the bit currently on the wire
  logic [15:0]      frame;
  logic             is_rd;
  logic             sdo;
  logic             sdo_oe;     // separate from dir: sdio stays released while idle
  logic [7:0]       rx;

  assign sdio = sdo_oe ? sdo : 1'bz;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register, whatever the order of
  // statements below.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset along with control so that an
      // aborted frame leaves no stale address, data or shift contents behind.
      state        <= S_INIT;
      cnt          <= '0;
      bit_idx      <= 4'd15;
      frame        <= '0;
      is_rd        <= 1'b0;
      sdo          <= 1'b0;
      sdo_oe       <= 1'b0;
      rx           <= '0;
      user_rd_data <= '0;
      user_op_busy <= 1'b1;
      user_wr_vild <= 1'b0;
      user_rd_vild <= 1'b0;
      rst_spi_pin  <= 1'b0;
      scb          <= 1'b1;
      sclk         <= 1'b0;
      dir          <= 1'b1;
    end else begin
      user_wr_vild <= 1'b0;
      user_rd_vild <= 1'b0;

      case (state)
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt          <= '0;
            rst_spi_pin  <= 1'b1;
            user_op_busy <= 1'b0;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_IDLE: begin
          // Write wins when both requests arrive together.
          if (user_wr_en || user_rd_en) begin
            is_rd        <= !user_wr_en;
            frame        <= user_wr_en ? {1'b0, user_wr_addr, user_wr_data}
                                       : {1'b1, user_rd_addr, 8'h00};
            sdo          <= !user_wr_en;   // first bit on the wire is r/w
            sdo_oe       <= 1'b1;
            scb          <= 1'b0;
            dir          <= 1'b1;
            bit_idx      <= 4'd15;
            cnt          <= '0;
            user_op_busy <= 1'b1;
            state        <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          // Rising sclk: the device samples our bit, we sample the device's.
          if (cnt == HALF_LAST) begin
            sclk <= 1'b1;
            rx   <= {rx[6:0], sdio};
          end
          if (cnt == DIV_LAST) begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (bit_idx == 4'd0) begin
              state <= S_CS_HOLD;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              sdo     <= frame[bit_idx - 1'b1];
              // Hand the line to the device for the eight data bits of a read.
              if (is_rd && bit_idx == 4'd8) begin
                dir    <= 1'b0;
                sdo_oe <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_CS_HOLD: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            scb    <= 1'b1;
            dir    <= 1'b1;
            sdo_oe <= 1'b0;
            if (is_rd) begin
              user_rd_vild <= 1'b1;
              user_rd_data <= rx;
            end else begin
              user_wr_vild <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          user_op_busy <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_adi_spi_7_8bit_driver.sv
// -----------------------------------------------------------------------------
// tb_adi_spi_7_8bit_driver
//
// Directed bench for adi_spi_7_8bit_driver. The DUT runs with a scaled clock
// ratio (DIV = 10, device reset = 2000 clocks) to keep the run short. A
// negedge monitor decodes the serial bus (sclk rises, shifted bits, bit
// period, dir during data bits, chip-select gaps) and acts as the device
// for reads, driving a preset byte on sdio whenever dir = 0.
// -----------------------------------------------------------------------------
module tb_adi_spi_7_8bit_driver;

  localparam int CLK_FRE      = 2_000_000;
  localparam int SCLK_FRE     = 200_000;
  localparam int DIV          = CLK_FRE / SCLK_FRE;
  localparam int INIT_CYC     = CLK_FRE / 1000;
  localparam int FRAME_BUDGET = 20 * DIV + 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       user_wr_en = 1'b0;
  logic [6:0] user_wr_addr = '0;
  logic [7:0] user_wr_data = '0;
  logic       user_rd_en = 1'b0;
  logic [6:0] user_rd_addr = '0;
  logic [7:0] user_rd_data;
  logic       user_op_busy;
  logic       user_wr_vild;
  logic       user_rd_vild;
  logic       rst_spi_pin;
  logic       scb;
  logic       sclk;
  wire        sdio;
  logic       dir;

  int checks   = 0;
  int failures = 0;

  // Bus monitor state.
  int         frame_rise   = 0;
  int         rise_total   = 0;
  int         frames       = 0;
  int         wr_cnt       = 0;
  int         rd_cnt       = 0;
  int         dir_low      = 0;
  int         period_err   = 0;
  int         cyc          = 0;
  int         last_rise    = 0;
  int         scb_high_run = 0;
  int         last_gap     = 0;
  logic       sclk_prev    = 1'b0;
  logic       scb_prev     = 1'b1;
  logic [15:0] mon_bits    = '0;
  logic [7:0]  vild_rd_data = '0;

  // Device-side model for reads.
  logic [7:0] rd_pattern = 8'h00;
  logic       tb_val;

  always #5 clk = ~clk;

  adi_spi_7_8bit_driver #(
    .CLK_FRE  (CLK_FRE),
    .SCLK_FRE (SCLK_FRE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .user_wr_en   (user_wr_en),
    .user_wr_addr (user_wr_addr),
    .user_wr_data (user_wr_data),
    .user_rd_en   (user_rd_en),
    .user_rd_addr (user_rd_addr),
    .user_rd_data (user_rd_data),
    .user_op_busy (user_op_busy),
    .user_wr_vild (user_wr_vild),
    .user_rd_vild (user_rd_vild),
    .rst_spi_pin  (rst_spi_pin),
    .scb          (scb),
    .sclk         (sclk),
    .sdio         (sdio),
    .dir          (dir)
  );

  // Bit k of the frame (k = 8..15 are the data bits) is presented before the
  // k-th sclk rise and held until the monitor has seen that rise.
  always_comb begin
    tb_val = 1'b0;
    if (frame_rise >= 8 && frame_rise < 16)
      tb_val = rd_pattern[3'(15 - frame_rise)];
  end

  assign sdio = dir ? 1'bz : tb_val;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (scb) begin
      frame_rise   <= 0;
      scb_high_run <= scb_high_run + 1;
    end else begin
      if (scb_prev) begin
        frames   <= frames + 1;
        last_gap <= scb_high_run;
      end
      scb_high_run <= 0;
      if (sclk && !sclk_prev) begin
        frame_rise <= frame_rise + 1;
        rise_total <= rise_total + 1;
        mon_bits   <= {mon_bits[14:0], sdio};
        if (frame_rise != 0 && (cyc - last_rise) != DIV)
          period_err <= period_err + 1;
        last_rise <= cyc;
        if (!dir)
          dir_low <= dir_low + 1;
      end
    end
    if (user_wr_vild)
      wr_cnt <= wr_cnt + 1;
    if (user_rd_vild) begin
      rd_cnt       <= rd_cnt + 1;
      vild_rd_data <= user_rd_data;
    end
    sclk_prev <= sclk;
    scb_prev  <= scb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wr(input logic [6:0] addr, input logic [7:0] data, input logic with_rd);
    user_wr_addr = addr;
    user_wr_data = data;
    user_wr_en   = 1'b1;
    user_rd_en   = with_rd;
    tick();
    user_wr_en   = 1'b0;
    user_rd_en   = 1'b0;
  endtask

  task automatic pulse_rd(input logic [6:0] addr);
    user_rd_addr = addr;
    user_rd_en   = 1'b1;
    tick();
    user_rd_en   = 1'b0;
  endtask

  // Waits until the total completion count reaches 'target', then until busy
  // drops; an expired budget is reported as a failed comparison.
  task automatic wait_done(input string tag, input int target);
    int n;
    n = 0;
    while ((wr_cnt + rd_cnt) < target && n < FRAME_BUDGET) begin
      tick();
      n++;
    end
    check({tag, "_vild_seen"}, 32'(wr_cnt + rd_cnt >= target), 32'd1);
    n = 0;
    while (user_op_busy && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_busy_low"}, 32'(user_op_busy), 32'd0);
  endtask

  initial begin
    int r0, f0, w0, d0, rd0;

    // ---------------- reset values ----------------
    repeat (5) tick();
    check("rst_busy",    32'(user_op_busy), 32'd1);
    check("rst_pin",     32'(rst_spi_pin),  32'd0);
    check("rst_scb",     32'(scb),          32'd1);
    check("rst_sclk",    32'(sclk),         32'd0);
    check("rst_dir",     32'(dir),          32'd1);
    check("rst_wr_vild", 32'(user_wr_vild), 32'd0);
    check("rst_rd_vild", 32'(user_rd_vild), 32'd0);
    check("rst_rd_data", 32'(user_rd_data), 32'd0);

    // ---------------- 1: device reset, request during INIT dropped ----------
    rst = 1'b0;
    for (int i = 1; i < INIT_CYC; i++) begin
      if (i == 50) begin
        user_wr_addr = 7'h12;
        user_wr_data = 8'h34;
        user_wr_en   = 1'b1;
      end
      tick();
      user_wr_en = 1'b0;
    end
    check("init_pin_still_low",  32'(rst_spi_pin),  32'd0);
    check("init_busy_still_high", 32'(user_op_busy), 32'd1);
    tick();
    check("init_pin_high", 32'(rst_spi_pin),  32'd1);
    check("init_busy_low", 32'(user_op_busy), 32'd0);
    repeat (3 * DIV) tick();
    check("init_req_dropped", 32'(frames), 32'd0);

    // ---------------- 2: write 0x4A / 0x55 ----------------
    r0 = rise_total; w0 = wr_cnt; d0 = dir_low; f0 = frames;
    pulse_wr(7'h4A, 8'h55, 1'b0);
    check("wr_busy_rises", 32'(user_op_busy), 32'd1);
    wait_done("wr", w0 + rd_cnt + 1);
    check("wr_bits",    32'(mon_bits),        32'h4A55);
    check("wr_rises",   32'(rise_total - r0), 32'd16);
    check("wr_period",  32'(period_err),      32'd0);
    check("wr_dir",     32'(dir_low - d0),    32'd0);
    check("wr_vild",    32'(wr_cnt - w0),     32'd1);
    check("wr_frames",  32'(frames - f0),     32'd1);
    check("wr_scb_end", 32'(scb),             32'd1);

    // ---------------- 3: read 0x5A, device returns 0xAA ----------------
    rd_pattern = 8'hAA;
    r0 = rise_total; rd0 = rd_cnt; d0 = dir_low; w0 = wr_cnt;
    pulse_rd(7'h5A);
    wait_done("rd", wr_cnt + rd0 + 1);
    check("rd_bits",       32'(mon_bits),        32'hDAAA);
    check("rd_rises",      32'(rise_total - r0), 32'd16);
    check("rd_dir_low",    32'(dir_low - d0),    32'd8);
    check("rd_vild",       32'(rd_cnt - rd0),    32'd1);
    check("rd_no_wr_vild", 32'(wr_cnt - w0),     32'd0);
    check("rd_data",       32'(user_rd_data),    32'hAA);
    check("rd_data_at_vild", 32'(vild_rd_data),  32'hAA);
    check("rd_dir_restored", 32'(dir),           32'd1);
    check("rd_period",     32'(period_err),      32'd0);

    // ---------------- 4: simultaneous wr/rd, read mid-frame dropped --------
    rd_pattern = 8'h0F;
    w0 = wr_cnt; rd0 = rd_cnt; f0 = frames;
    pulse_wr(7'h11, 8'h3C, 1'b1);
    repeat (5 * DIV) tick();
    pulse_rd(7'h22);
    wait_done("both", w0 + rd0 + 1);
    check("both_bits",    32'(mon_bits),      32'h113C);
    check("both_wr_vild", 32'(wr_cnt - w0),   32'd1);
    check("both_rd_vild", 32'(rd_cnt - rd0),  32'd0);
    repeat (40 * DIV) tick();
    check("both_one_frame", 32'(frames - f0), 32'd1);
    check("both_rd_held",   32'(user_rd_data), 32'hAA);

    // ---------------- 5: reset during bit 5 of a write ----------------
    w0 = wr_cnt; r0 = rise_total; f0 = frames;
    pulse_wr(7'h33, 8'hCC, 1'b0);
    begin
      int n;
      n = 0;
      while ((rise_total - r0) < 5 && n < FRAME_BUDGET) begin
        tick();
        n++;
      end
      check("abort_reached_bit5", 32'(rise_total - r0 >= 5), 32'd1);
    end
    repeat (DIV / 2 + 2) tick();
    rst = 1'b1;
    tick();
    check("abort_scb",  32'(scb),          32'd1);
    check("abort_sclk", 32'(sclk),         32'd0);
    check("abort_dir",  32'(dir),          32'd1);
    check("abort_busy", 32'(user_op_busy), 32'd1);
    check("abort_pin",  32'(rst_spi_pin),  32'd0);
    rst = 1'b0;
    repeat (INIT_CYC - 1) tick();
    check("abort_init_pin_low", 32'(rst_spi_pin), 32'd0);
    tick();
    check("abort_init_pin_high", 32'(rst_spi_pin), 32'd1);
    check("abort_no_vild",   32'(wr_cnt - w0), 32'd0);
    check("abort_frames",    32'(frames - f0), 32'd1);
    check("abort_rd_data_cleared", 32'(user_rd_data), 32'd0);

    // ---------------- 6: back-to-back writes ----------------
    w0 = wr_cnt; f0 = frames;
    pulse_wr(7'h01, 8'h80, 1'b0);
    wait_done("b2b_a", w0 + rd_cnt + 1);
    check("b2b_a_bits", 32'(mon_bits), 32'h0180);
    pulse_wr(7'h7F, 8'h01, 1'b0);
    wait_done("b2b_b", w0 + rd_cnt + 2);
    check("b2b_b_bits", 32'(mon_bits),        32'h7F01);
    check("b2b_vild",   32'(wr_cnt - w0),     32'd2);
    check("b2b_frames", 32'(frames - f0),     32'd2);
    check("b2b_gap",    32'(last_gap >= 1),   32'd1);
    check("b2b_period", 32'(period_err),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
